// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ext_op encodings, register-zero address and default datapath widths.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } extOpE;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_REG_AW = 5;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/alu_b_operand_stage_if.sv
// ID/EX handshake bundle for the ALU operand-B stage: request from ID, registered operand to EX.
interface alu_b_operand_stage_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = 5
);
    logic               in_valid;
    logic               in_ready;
    logic               sel_imm;
    logic [1:0]         ext_op;
    logic [15:0]        imm16;
    logic [REG_AW-1:0]  rt_addr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   operand_b;
    logic [NUM_FWD-1:0] fwd_hit;

    modport master (
        output in_valid, sel_imm, ext_op, imm16, rt_addr, out_ready,
        input  in_ready, out_valid, operand_b, fwd_hit
    );

    modport slave (
        input  in_valid, sel_imm, ext_op, imm16, rt_addr, out_ready,
        output in_ready, out_valid, operand_b, fwd_hit
    );
endinterface

// File: rtl/alub_fwd_pick.sv
// Priority forwarding match for operand B: lowest-index matching channel wins, $0 never matches.
module alub_fwd_pick
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = DEFAULT_REG_AW
) (
    input  logic [REG_AW-1:0]         rt_addr,
    input  logic [WIDTH-1:0]          grf_rd2,
    input  logic [NUM_FWD-1:0]        fwd_en,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
    output logic [NUM_FWD-1:0]        winHot,
    output logic [WIDTH-1:0]          pickData,
    output logic                      hazard
);

    logic found;
    logic notZero;

    assign notZero = (rt_addr != REG_AW'(REG_ZERO));

    always_comb begin
        winHot   = '0;
        pickData = grf_rd2;
        hazard   = 1'b0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!found && notZero && fwd_en[i] &&
                (fwd_addr[i*REG_AW +: REG_AW] == rt_addr)) begin
                found     = 1'b1;
                winHot[i] = 1'b1;
                pickData  = fwd_data[i*WIDTH +: WIDTH];
                // Only the winner's readiness matters; pending lower-priority matches are shadowed.
                hazard    = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/alu_b_operand_stage.sv
// Registered ALU operand-B selector between ID and EX with forwarding, load-use stall and flush.
// Optional ALUB_STALL_CNT_EN adds a saturating stall_cnt output.
module alu_b_operand_stage
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = DEFAULT_REG_AW
) (
    input  logic                      clk,
    input  logic                      reset_n,
    alu_b_operand_stage_if.slave      bus,
    input  logic [WIDTH-1:0]          grf_rd2,
    input  logic [NUM_FWD-1:0]        fwd_en,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
    input  logic                      flush
`ifdef ALUB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    logic [NUM_FWD-1:0] winHot;
    logic [WIDTH-1:0]   pickData;
    logic               pickHazard;
    logic               hazard;
    logic               accept;
    logic [WIDTH-1:0]   immExt;
    logic [WIDTH-1:0]   operandD;
    logic [NUM_FWD-1:0] fwdHitD;

    logic               outValidQ;
    logic [WIDTH-1:0]   operandQ;
    logic [NUM_FWD-1:0] fwdHitQ;

    alub_fwd_pick #(
        .WIDTH   (WIDTH),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) uPick (
        .rt_addr     (bus.rt_addr),
        .grf_rd2     (grf_rd2),
        .fwd_en      (fwd_en),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .winHot      (winHot),
        .pickData    (pickData),
        .hazard      (pickHazard)
    );

    always_comb begin
        immExt = '0;
        case (extOpE'(bus.ext_op))
            EXT_SIGN: immExt = WIDTH'($signed(bus.imm16));
            EXT_LUI:  immExt[31:16] = bus.imm16;
            default:  immExt[15:0] = bus.imm16;
        endcase
    end

    assign hazard   = !bus.sel_imm && pickHazard;
    assign operandD = bus.sel_imm ? immExt : pickData;
    assign fwdHitD  = bus.sel_imm ? '0 : winHot;

    // Flush blocks capture so a squashed request never reaches EX.
    assign bus.in_ready = !flush && !hazard && (!outValidQ || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValidQ <= 1'b0;
            operandQ  <= '0;
            fwdHitQ   <= '0;
        end else if (flush) begin
            outValidQ <= 1'b0;
            fwdHitQ   <= '0;
        end else if (accept) begin
            outValidQ <= 1'b1;
            operandQ  <= operandD;
            fwdHitQ   <= fwdHitD;
        end else if (bus.out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    assign bus.out_valid = outValidQ;
    assign bus.operand_b = operandQ;
    assign bus.fwd_hit   = fwdHitQ;

`ifdef ALUB_STALL_CNT_EN
    logic [15:0] stallCntQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCntQ <= '0;
        end else if (bus.in_valid && hazard && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Directed bench for alu_b_operand_stage: vector table plus stall, hold/flush and async-reset sequences.
module tb_alu_b_operand_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned NF = 2;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  grf_rd2;
    logic [NF-1:0] fwd_en;
    logic [NF-1:0] fwd_pending;
    logic [AW-1:0] a0, a1;
    logic [W-1:0]  d0, d1;
    logic          flush;
`ifdef ALUB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    alu_b_operand_stage_if #(.WIDTH(W), .NUM_FWD(NF), .REG_AW(AW)) bus ();

    alu_b_operand_stage #(
        .WIDTH   (W),
        .NUM_FWD (NF),
        .REG_AW  (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .grf_rd2     (grf_rd2),
        .fwd_en      (fwd_en),
        .fwd_pending (fwd_pending),
        .fwd_addr    ({a1, a0}),
        .fwd_data    ({d1, d0}),
        .flush       (flush)
`ifdef ALUB_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          selImm;
        logic [1:0]    extOp;
        logic [15:0]   imm;
        logic [AW-1:0] rt;
        logic [W-1:0]  grf;
        logic [NF-1:0] en;
        logic [NF-1:0] pend;
        logic [AW-1:0] fa0;
        logic [AW-1:0] fa1;
        logic [W-1:0]  fd0;
        logic [W-1:0]  fd1;
        logic [W-1:0]  expOp;
        logic [NF-1:0] expHit;
    } vecT;

    vecT vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vecT v);
        bus.sel_imm  = v.selImm;
        bus.ext_op   = v.extOp;
        bus.imm16    = v.imm;
        bus.rt_addr  = v.rt;
        grf_rd2      = v.grf;
        fwd_en       = v.en;
        fwd_pending  = v.pend;
        a0           = v.fa0;
        a1           = v.fa1;
        d0           = v.fd0;
        d1           = v.fd1;
    endtask

    initial begin
        // selImm extOp imm rt grf en pend a0 a1 d0 d1 expOp expHit
        vecs[0]  = '{1'b1, 2'b01, 16'h8001, 5'd0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'hFFFF8001, 2'b00};
        vecs[1]  = '{1'b1, 2'b10, 16'h1234, 5'd0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h12340000, 2'b00};
        vecs[2]  = '{1'b1, 2'b00, 16'hFFFF, 5'd0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h0000FFFF, 2'b00};
        vecs[3]  = '{1'b1, 2'b11, 16'h8001, 5'd0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h00008001, 2'b00};
        vecs[4]  = '{1'b1, 2'b00, 16'h0005, 5'd8, 32'h0, 2'b11, 2'b11, 5'd8, 5'd8,
                     32'hAAAA0000, 32'h5555, 32'h00000005, 2'b00};
        vecs[5]  = '{1'b0, 2'b00, 16'h0, 5'd8, 32'h11111111, 2'b11, 2'b00, 5'd8, 5'd8,
                     32'hAAAA0000, 32'h5555, 32'hAAAA0000, 2'b01};
        vecs[6]  = '{1'b0, 2'b00, 16'h0, 5'd8, 32'h11111111, 2'b10, 2'b00, 5'd8, 5'd8,
                     32'hAAAA0000, 32'h5555, 32'h00005555, 2'b10};
        vecs[7]  = '{1'b0, 2'b00, 16'h0, 5'd3, 32'hDEADBEEF, 2'b11, 2'b00, 5'd4, 5'd5,
                     32'h1, 32'h2, 32'hDEADBEEF, 2'b00};
        vecs[8]  = '{1'b0, 2'b00, 16'h0, 5'd0, 32'h0, 2'b01, 2'b00, 5'd0, 5'd0,
                     32'h1, 32'h2, 32'h00000000, 2'b00};
        vecs[9]  = '{1'b0, 2'b00, 16'h0, 5'd4, 32'h0, 2'b11, 2'b10, 5'd4, 5'd4,
                     32'h0BADCAFE, 32'h77, 32'h0BADCAFE, 2'b01};
        vecs[10] = '{1'b0, 2'b00, 16'h0, 5'd6, 32'h0, 2'b11, 2'b00, 5'd7, 5'd6,
                     32'h3, 32'h600D600D, 32'h600D600D, 2'b10};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        apply(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_operand", bus.operand_b, 32'h0);
        check("reset_fwd_hit", 32'(bus.fwd_hit), 32'h0);
`ifdef ALUB_STALL_CNT_EN
        check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
`endif

        @(negedge clk);
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            bus.in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("vec%0d_operand", i), bus.operand_b, vecs[i].expOp);
            check($sformatf("vec%0d_fwd_hit", i), 32'(bus.fwd_hit), 32'(vecs[i].expHit));
        end

        // Load-use stall on channel 0 for two cycles.
        @(negedge clk);
        bus.sel_imm = 1'b0;
        bus.rt_addr = 5'd9;
        fwd_en      = 2'b01;
        fwd_pending = 2'b01;
        a0          = 5'd9;
        d0          = 32'hCAFEF00D;
        #1;
        check("stall_in_ready_c1", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("stall_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        #1;
        check("stall_in_ready_c2", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
`ifdef ALUB_STALL_CNT_EN
        check("stall_cnt_2", 32'(stall_cnt), 32'h2);
`endif
        fwd_pending = 2'b00;
        #1;
        check("stall_release_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("stall_capture", bus.operand_b, 32'hCAFEF00D);
        check("stall_capture_hit", 32'(bus.fwd_hit), 32'h1);

        // Hold under backpressure, then flush.
        @(negedge clk);
        bus.rt_addr = 5'd8;
        a0          = 5'd8;
        d0          = 32'hAAAA0000;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.sel_imm   = 1'b1;
        bus.ext_op    = 2'b00;
        bus.imm16     = 16'h0099;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_operand", k), bus.operand_b, 32'hAAAA0000);
            check($sformatf("hold%0d_out_valid", k), 32'(bus.out_valid), 32'h1);
            check($sformatf("hold%0d_fwd_hit", k), 32'(bus.fwd_hit), 32'h1);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check("flush_fwd_hit", 32'(bus.fwd_hit), 32'h0);
        check("flush_no_capture", bus.operand_b, 32'hAAAA0000);
        @(negedge clk);
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_flush_capture", bus.operand_b, 32'h00000099);
        check("post_flush_valid", 32'(bus.out_valid), 32'h1);

        // Asynchronous reset between edges drops the held operand.
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_operand", bus.operand_b, 32'h0);
`ifdef ALUB_STALL_CNT_EN
        check("async_rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
